// File: rtl/pot_spi_responder.sv
// SPI responder for the 16-bit digital-potentiometer command protocol.
// SPI_CLK/SYNC/DIN are oversampled in the clk domain. Frames are assembled
// and decoded, and the wiper, control and response state is held here.
// SDO echoes the previous frame, or returns readback data after a read command.
module pot_spi_responder #(
  parameter int unsigned SPI_DIV_MIN = 8,
  parameter logic [9:0]  RDAC_RESET  = 10'h200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPI_CLK,
  input  logic       SYNC,
  input  logic       DIN,
  output logic       SDO,
  output logic [9:0] rdac,
  output logic [2:0] ctrl,
  output logic [3:0] cmd,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       wr_blocked
);

  // The synchronizer plus edge detect needs at least 4 clk per SPI half-period.
  if (SPI_DIV_MIN < 4) begin : g_div_check
    $error("SPI_DIV_MIN must be at least 4");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDecode, StWaitHi} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_q, sync_q;
  logic [1:0]  din_q;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] resp_q, resp_d;
  logic [15:0] tx_q, tx_d;
  logic        sdo_q, sdo_d;
  logic [9:0]  rdac_q, rdac_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [3:0]  cmd_q, cmd_d;

  logic sclk_fall, sclk_rise, sync_fall, sync_rise, sync_hi;
  logic frame_ok;

  // Two-flop synchronizers; the third SPI_CLK/SYNC stage feeds edge detection.
  // Cleared to 0 so a frame in flight at reset release never looks like a fresh SYNC fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      sync_q <= '0;
      din_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], SPI_CLK};
      sync_q <= {sync_q[1:0], SYNC};
      din_q  <= {din_q[0], DIN};
    end
  end

  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sync_fall = sync_q[2] & ~sync_q[1];
  assign sync_rise = ~sync_q[2] & sync_q[1];
  assign sync_hi   = sync_q[1];

  assign frame_ok = (cnt_q == 5'd16) && (shreg_q[15:14] == 2'b00);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StWaitHi;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitHi: if (sync_hi) state_d = StIdle;
      StIdle: begin
        if (sync_fall)     state_d = StShift;
        else if (!sync_hi) state_d = StWaitHi;
      end
      StShift:  if (sync_rise) state_d = StDecode;
      StDecode: state_d = StIdle;
      default:  state_d = StWaitHi;
    endcase
  end

  // FSM outputs: one-clk pulses while in DECODE.
  always_comb begin
    frame_valid = 1'b0;
    frame_err   = 1'b0;
    wr_blocked  = 1'b0;
    if (state_q == StDecode) begin
      frame_valid = frame_ok;
      frame_err   = !frame_ok;
      wr_blocked  = frame_ok && (shreg_q[13:10] == 4'd1) && !ctrl_q[1];
    end
  end

  // Datapath next-state: shifting, SDO sequencing and command decode.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    tx_d    = tx_q;
    sdo_d   = 1'b0;
    rdac_d  = rdac_q;
    ctrl_d  = ctrl_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      StIdle: begin
        if (sync_fall) begin
          cnt_d = '0;
          tx_d  = resp_q;
          sdo_d = resp_q[15];
        end
      end
      StShift: begin
        sdo_d = sdo_q;
        // Sampling still happens in the cycle SYNC rise is seen, so a
        // coincident last falling edge is not lost.
        if (sclk_fall) begin
          shreg_d = {shreg_q[14:0], din_q[1]};
          cnt_d   = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
        end
        if (sclk_rise) begin
          tx_d  = {tx_q[14:0], 1'b0};
          sdo_d = tx_q[14];
        end
      end
      StDecode: begin
        if (frame_ok) begin
          cmd_d  = shreg_q[13:10];
          resp_d = shreg_q;
          case (shreg_q[13:10])
            4'd1: if (ctrl_q[1]) rdac_d = shreg_q[9:0];
            4'd2: resp_d = {6'b0, rdac_q};
            4'd4: rdac_d = RDAC_RESET;
            4'd6: ctrl_d = shreg_q[2:0];
            4'd7: resp_d = {13'b0, ctrl_q};
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      tx_q    <= '0;
      sdo_q   <= 1'b0;
      rdac_q  <= RDAC_RESET;
      ctrl_q  <= '0;
      cmd_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      tx_q    <= tx_d;
      sdo_q   <= sdo_d;
      rdac_q  <= rdac_d;
      ctrl_q  <= ctrl_d;
      cmd_q   <= cmd_d;
    end
  end

  assign SDO  = sdo_q;
  assign rdac = rdac_q;
  assign ctrl = ctrl_q;
  assign cmd  = cmd_q;

endmodule

// File: tb/tb_pot_spi_responder.sv
// Directed bench for pot_spi_responder: table of frames with hand-computed
// results, plus hand-written readback, reset and clock-rate sequences.
module tb_pot_spi_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       SPI_CLK = 1'b0;
  logic       SYNC = 1'b1;
  logic       DIN = 1'b0;
  logic       SDO;
  logic [9:0] rdac;
  logic [2:0] ctrl;
  logic [3:0] cmd;
  logic       frame_valid, frame_err, wr_blocked;

  int n_checks = 0;
  int n_pass = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_blk = 0;

  pot_spi_responder dut (
    .clk        (clk),
    .reset      (reset),
    .SPI_CLK    (SPI_CLK),
    .SYNC       (SYNC),
    .DIN        (DIN),
    .SDO        (SDO),
    .rdac       (rdac),
    .ctrl       (ctrl),
    .cmd        (cmd),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .wr_blocked (wr_blocked)
  );

  always #5 clk = ~clk;

  // Running pulse counts, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (frame_err)   n_err++;
    if (wr_blocked)  n_blk++;
  end

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    logic [9:0]  rdac;
    logic [2:0]  ctrl;
    logic [3:0]  cmd;
    int          nv;
    int          ne;
    int          nb;
  } vec_t;

  vec_t vecs[12];

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Send nbits of val MSB first; SDO is captured just before each rising edge.
  task automatic send(input logic [31:0] val, input int nbits, input int h,
                      output logic [15:0] cap);
    int lead;
    lead = (h < 6) ? 6 : h;
    cap = '0;
    SYNC = 1'b0;
    wait_n(lead);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) cap[15-i] = SDO;
      DIN = val[nbits-1-i];
      SPI_CLK = 1'b1;
      wait_n(h);
      SPI_CLK = 1'b0;
      wait_n(h);
    end
    SYNC = 1'b1;
    DIN = 1'b0;
    wait_n(h + 10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    SYNC = 1'b1;
    SPI_CLK = 1'b0;
    DIN = 1'b0;
    wait_n(4);
    reset = 1'b0;
    wait_n(6);
  endtask

  initial begin
    logic [15:0] cap;
    int v0, e0, b0;
    logic [15:0] fr;
    logic [9:0]  m_rdac;
    logic [2:0]  m_ctrl;

    vecs[0]  = '{32'h0555,  16, 10'h200, 3'b000, 4'h1, 1, 0, 1};
    vecs[1]  = '{32'h1000,  16, 10'h200, 3'b000, 4'h4, 1, 0, 0};
    vecs[2]  = '{32'h1802,  16, 10'h200, 3'b010, 4'h6, 1, 0, 0};
    vecs[3]  = '{32'h0555,  16, 10'h155, 3'b010, 4'h1, 1, 0, 0};
    vecs[4]  = '{32'h0800,  16, 10'h155, 3'b010, 4'h2, 1, 0, 0};
    vecs[5]  = '{32'h1800,  16, 10'h155, 3'b000, 4'h6, 1, 0, 0};
    vecs[6]  = '{32'h0433,  16, 10'h155, 3'b000, 4'h1, 1, 0, 1};
    vecs[7]  = '{32'h0555,  15, 10'h155, 3'b000, 4'h1, 0, 1, 0};
    vecs[8]  = '{32'h11802, 17, 10'h155, 3'b000, 4'h1, 0, 1, 0};
    vecs[9]  = '{32'hC000,  16, 10'h155, 3'b000, 4'h1, 0, 1, 0};
    vecs[10] = '{32'h1C00,  16, 10'h155, 3'b000, 4'h7, 1, 0, 0};
    vecs[11] = '{32'h2000,  16, 10'h155, 3'b000, 4'h8, 1, 0, 0};

    do_reset();
    chk("reset_rdac", 32'(rdac), 32'h200);
    chk("reset_ctrl", 32'(ctrl), 32'h0);
    chk("reset_cmd", 32'(cmd), 32'h0);
    chk("reset_sdo", 32'(SDO), 32'h0);
    chk("reset_pulses", 32'(n_valid + n_err + n_blk), 32'h0);

    for (int k = 0; k < 12; k++) begin
      v0 = n_valid; e0 = n_err; b0 = n_blk;
      send(vecs[k].frame, vecs[k].nbits, 8, cap);
      chk($sformatf("vec%0d_rdac", k), 32'(rdac), 32'(vecs[k].rdac));
      chk($sformatf("vec%0d_ctrl", k), 32'(ctrl), 32'(vecs[k].ctrl));
      chk($sformatf("vec%0d_cmd", k), 32'(cmd), 32'(vecs[k].cmd));
      chk($sformatf("vec%0d_valid", k), 32'(n_valid - v0), 32'(vecs[k].nv));
      chk($sformatf("vec%0d_err", k), 32'(n_err - e0), 32'(vecs[k].ne));
      chk($sformatf("vec%0d_blk", k), 32'(n_blk - b0), 32'(vecs[k].nb));
    end

    // Readback and echo through SDO.
    do_reset();
    send(32'h0800, 16, 8, cap);
    send(32'h0000, 16, 8, cap);
    chk("sdo_read_rdac", 32'(cap), 32'h0200);
    send(32'h1802, 16, 8, cap);
    send(32'h0000, 16, 8, cap);
    chk("sdo_echo", 32'(cap), 32'h1802);
    send(32'h1C00, 16, 8, cap);
    send(32'h0000, 16, 8, cap);
    chk("sdo_read_ctrl", 32'(cap), 32'h0002);
    chk("sdo_idle", 32'(SDO), 32'h0);

    // Reset mid-frame, released with SYNC still low.
    v0 = n_valid; e0 = n_err; b0 = n_blk;
    fr = 16'h1802;
    SYNC = 1'b0;
    wait_n(8);
    for (int i = 0; i < 8; i++) begin
      DIN = fr[15-i]; SPI_CLK = 1'b1; wait_n(8); SPI_CLK = 1'b0; wait_n(8);
    end
    reset = 1'b1;
    wait_n(3);
    reset = 1'b0;
    wait_n(3);
    for (int i = 8; i < 16; i++) begin
      DIN = fr[15-i]; SPI_CLK = 1'b1; wait_n(8); SPI_CLK = 1'b0; wait_n(8);
    end
    SYNC = 1'b1;
    DIN = 1'b0;
    wait_n(20);
    chk("midrst_valid", 32'(n_valid - v0), 32'h0);
    chk("midrst_err", 32'(n_err - e0), 32'h0);
    chk("midrst_ctrl", 32'(ctrl), 32'h0);
    v0 = n_valid;
    send(32'h1802, 16, 8, cap);
    chk("after_midrst_ctrl", 32'(ctrl), 32'h2);
    chk("after_midrst_valid", 32'(n_valid - v0), 32'h1);

    // SPI_CLK half-period sweep with random valid frames against a small model.
    m_rdac = 10'h200;
    m_ctrl = 3'b010;
    for (int h = 4; h <= 16; h++) begin
      for (int r = 0; r < 2; r++) begin
        fr = {2'b00, 4'($urandom_range(15)), 10'($urandom)};
        case (fr[13:10])
          4'd1: if (m_ctrl[1]) m_rdac = fr[9:0];
          4'd4: m_rdac = 10'h200;
          4'd6: m_ctrl = fr[2:0];
          default: ;
        endcase
        v0 = n_valid;
        send(32'(fr), 16, h, cap);
        chk($sformatf("sweep_h%0d_cmd", h), 32'(cmd), 32'(fr[13:10]));
        chk($sformatf("sweep_h%0d_rdac", h), 32'(rdac), 32'(m_rdac));
        chk($sformatf("sweep_h%0d_ctrl", h), 32'(ctrl), 32'(m_ctrl));
        chk($sformatf("sweep_h%0d_valid", h), 32'(n_valid - v0), 32'h1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pot_spi_responder.md
# pot_spi_responder

Synthesizable SPI responder (slave) for the 16-bit digital-potentiometer command protocol that the power-supply control path drives on SYNC/SPI_CLK/DIN. It oversamples the SPI lines in the system clock domain, assembles frames, decodes the reset, control-write, RDAC-write and readback commands, and holds the resulting wiper and control state. The block is used both as an on-chip bus monitor (loopback verification of pot writes) and as a pot emulator on boards without the physical part.

## Interface
- SPI_DIV_MIN, 8: minimum SPI_CLK half-period in clk cycles that the block is guaranteed to track; documentation bound only, no logic.
- RDAC_RESET, 10'h200: wiper value loaded on reset and on the reset command.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- SPI_CLK  in  1  SPI clock from master, CPOL=0, asynchronous to clk.
- SYNC  in  1  frame select, active low.
- DIN  in  1  serial data from master, MSB first.
- SDO  out  1  serial data to master.
- rdac  out  10  current wiper code.
- ctrl  out  3  control register {C2 calib-disable, C1 RDAC write enable, C0 50-TP enable}.
- cmd  out  4  command field of last accepted frame.
- frame_valid  out  1  one-clk pulse: well-formed 16-bit frame decoded.
- frame_err  out  1  one-clk pulse: frame ended with bit count ≠ 16 or bits[15:14] ≠ 00.
- wr_blocked  out  1  one-clk pulse: RDAC write rejected because ctrl[1]=0.

## Operation
- SPI_CLK, SYNC, DIN each pass a 2-flop synchronizer; a third stage gives edge detection. All logic runs on clk.
- Sampling: DIN sampled on synchronized SPI_CLK falling edge while SYNC low; shift register 16 bits, left shift, bit counter 5 bits saturating at 17.
- States: IDLE (SYNC high), SHIFT (SYNC low, armed), DECODE (one cycle after SYNC rising edge), WAIT_HI (SYNC low but not armed).
- IDLE -> SHIFT on SYNC falling edge: counter cleared, SDO loads response[15].
- SHIFT -> DECODE on SYNC rising edge. DECODE -> IDLE unconditionally.
- Frame checks in DECODE: count must equal 16 and bits[15:14]=00, else frame_err, no state change, response register unchanged.
- Command = bits[13:10], data = bits[9:0]:
  - 0 NOP: no change.
  - 1 write RDAC: if ctrl[1] then rdac <= data else wr_blocked.
  - 2 read RDAC: response <= {6'b0, rdac}.
  - 3 store 50-TP: accepted, no state change.
  - 4 reset: rdac <= RDAC_RESET.
  - 6 write control: ctrl <= data[2:0].
  - 7 read control: response <= {13'b0, ctrl}.
  - 5, 8-15: accepted as NOP.
- For every valid frame that is not a read command, response <= received frame (daisy-chain echo).
- SDO: on synchronized SPI_CLK rising edge in SHIFT, SDO shifts to next response bit; holds 0 in IDLE.
- cmd updates on every valid frame.

## Timing
- Reset values: rdac=RDAC_RESET, ctrl=3'b000, cmd=0, response=0, SDO=0, all pulses 0, state WAIT_HI.
- Input-to-edge-detect latency: 3 clk. Bits are lost if SPI_CLK half-period < 4 clk; SPI_DIV_MIN=8 is the supported bound.
- SYNC rising detected at cycle E: DECODE is at E+1. rdac/ctrl/cmd/response update and pulses assert at E+1 for exactly one clk.
- SPI_CLK edges while SYNC high are ignored. More than 16 falling edges set the count to 17, which yields frame_err.
- Reset deasserted while SYNC is low: stay in WAIT_HI until SYNC high, so no partial frame is decoded. Reset asserted mid-frame discards the frame.
- Simultaneous SYNC rise and SPI_CLK fall in the same synchronized cycle: the bit is sampled before the frame closes.
- Back-to-back frames with SYNC high for ≥ 1 SPI_CLK half-period are supported.

## Test plan
- Power-up sequence with SYNC high around each frame: frames 16'h1000, 16'h1802, then 16'h0400|D with D=10'h155. Required: rdac=10'h200 after the first frame, ctrl=3'b010 after the second, rdac=10'h155 after the third, and three frame_valid pulses.
- From reset, send 16'h0555. Required: wr_blocked pulse, rdac stays 10'h200.
- Frame 16'h0800 followed by NOP 16'h0000. Required: SDO during the NOP shifts out 16'h0200 MSB first.
- 15-bit frame, then 17-bit frame, then 16'hC000. Required: three frame_err pulses, no state change.
- Assert reset after 8 bits, then deassert with SYNC still low and clock 8 more bits before SYNC rises. Required: no frame_valid and no frame_err; the next full frame 16'h1802 decodes normally.
- Sweep SPI_CLK half-period from 4 to 16 clk with random 16-bit valid frames. Required: decoded fields match the transmitted frames.
